// File: rtl/tetris_line_clear.sv
// tetris_line_clear
//   Holds a 20x10 Tetris playfield, merges landed pieces into it and removes
//   completed rows, scanning one row per clock from the bottom (row 19) up.
//   Cell (row r, col c) lives at bit r*10+c; row 0 is the top row.
//
// Ports
//   clk             : sole clock, rising edge
//   reset           : asynchronous, active-high reset
//   lock_valid      : request to merge lock_mask into the playfield
//   lock_mask       : cells of the landed piece (sampled only when accepted)
//   clear_grid      : empty the playfield and counters (IDLE only, wins over lock)
//   lock_ready      : high only in IDLE
//   grid_state      : registered playfield
//   busy            : high in any state other than IDLE
//   clear_done      : one-cycle pulse closing each lock sequence
//   lines_this_lock : rows cleared by the last lock (saturates at 7)
//   lines_total     : cumulative cleared rows, saturating at 65535
//   top_out         : row 0 non-empty after the last lock sequence
//   overlap_err     : sticky, a lock overlapped occupied cells
//   dbg_state       : current FSM state (0 IDLE, 1 MERGE, 2 SCAN, 3 DONE)
//
// Handshake: a lock is accepted on a rising edge where lock_valid && lock_ready
// and clear_grid is low; lock_ready stays low until the sequence finishes.
module tetris_line_clear (
  input  logic         clk,
  input  logic         reset,
  input  logic         lock_valid,
  input  logic [199:0] lock_mask,
  input  logic         clear_grid,
  output logic         lock_ready,
  output logic [199:0] grid_state,
  output logic         busy,
  output logic         clear_done,
  output logic [2:0]   lines_this_lock,
  output logic [15:0]  lines_total,
  output logic         top_out,
  output logic         overlap_err,
  output logic [1:0]   dbg_state
);

  localparam int ROWS = 20;
  localparam int COLS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [199:0]  r_grid;
  logic [199:0]  r_mask;
  logic [4:0]    r_ptr;
  logic [2:0]    r_k;
  logic [2:0]    r_lines_this;
  logic [15:0]   r_lines_total;
  logic          r_top_out;
  logic          r_overlap;

  logic          w_row_full;
  logic [199:0]  w_shifted;
  logic          w_overlap;
  logic [16:0]   w_total_sum;
  logic [15:0]   w_total_sat;
  logic          w_scan_last;

  // Fullness of the row under the scan pointer.
  always_comb begin
    w_row_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_ptr == 5'(r)) w_row_full = &r_grid[r*COLS +: COLS];
    end
  end

  // Removing row ptr: every row at or above it drops one row, row 0 empties,
  // rows below ptr stay where they are.
  always_comb begin
    w_shifted = r_grid;
    w_shifted[COLS-1:0] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (5'(r) <= r_ptr) w_shifted[r*COLS +: COLS] = r_grid[(r-1)*COLS +: COLS];
    end
  end

  assign w_overlap   = |(r_grid & r_mask);
  assign w_total_sum = {1'b0, r_lines_total} + {14'd0, r_k};
  assign w_total_sat = w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
  assign w_scan_last = (r_state == SCAN) && !w_row_full && (r_ptr == 5'd0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!clear_grid && lock_valid) w_next_state = MERGE;
      MERGE:   w_next_state = SCAN;
      SCAN:    if (w_scan_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath. The per-lock results are committed on the edge that enters
  // DONE, so they are already valid while clear_done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grid        <= '0;
      r_mask        <= '0;
      r_ptr         <= '0;
      r_k           <= '0;
      r_lines_this  <= '0;
      r_lines_total <= '0;
      r_top_out     <= 1'b0;
      r_overlap     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_grid) begin
            r_grid        <= '0;
            r_lines_this  <= '0;
            r_lines_total <= '0;
            r_top_out     <= 1'b0;
            r_overlap     <= 1'b0;
          end else if (lock_valid) begin
            r_mask <= lock_mask;
          end
        end
        MERGE: begin
          r_grid <= r_grid | r_mask;
          if (w_overlap) r_overlap <= 1'b1;
          r_ptr  <= 5'd19;
          r_k    <= 3'd0;
        end
        SCAN: begin
          if (w_row_full) begin
            // Pointer holds: the row that just dropped in is rescanned.
            r_grid <= w_shifted;
            if (r_k != 3'd7) r_k <= r_k + 3'd1;
          end else if (r_ptr == 5'd0) begin
            r_lines_this  <= r_k;
            r_lines_total <= w_total_sat;
            r_top_out     <= |r_grid[COLS-1:0];
          end else begin
            r_ptr <= r_ptr - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lock_ready      = (r_state == IDLE);
  assign busy            = (r_state != IDLE);
  assign clear_done      = (r_state == DONE);
  assign grid_state      = r_grid;
  assign lines_this_lock = r_lines_this;
  assign lines_total     = r_lines_total;
  assign top_out         = r_top_out;
  assign overlap_err     = r_overlap;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_tetris_line_clear.sv
module tb_tetris_line_clear;

  logic         clk;
  logic         reset;
  logic         lock_valid;
  logic [199:0] lock_mask;
  logic         clear_grid;
  logic         lock_ready;
  logic [199:0] grid_state;
  logic         busy;
  logic         clear_done;
  logic [2:0]   lines_this_lock;
  logic [15:0]  lines_total;
  logic         top_out;
  logic         overlap_err;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  tetris_line_clear dut (
    .clk             (clk),
    .reset           (reset),
    .lock_valid      (lock_valid),
    .lock_mask       (lock_mask),
    .clear_grid      (clear_grid),
    .lock_ready      (lock_ready),
    .grid_state      (grid_state),
    .busy            (busy),
    .clear_done      (clear_done),
    .lines_this_lock (lines_this_lock),
    .lines_total     (lines_total),
    .top_out         (top_out),
    .overlap_err     (overlap_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Row clearing as a whole: drop every full row, let the remaining rows
  // fall to the bottom in order, empty rows fill in at the top.
  function automatic void clear_full_rows(input logic [199:0] g, output logic [199:0] o,
                                          output int n);
    logic [9:0] kept[$];
    logic [9:0] row;
    n = 0;
    o = '0;
    for (int r = 19; r >= 0; r--) begin
      row = g[r*10 +: 10];
      if (row == 10'h3FF) n++;
      else kept.push_back(row);
    end
    for (int i = 0; i < kept.size(); i++) o[(19-i)*10 +: 10] = kept[i];
  endfunction

  int           m_cnt;        // cycles of busy remaining (0 = idle)
  logic [199:0] m_grid;
  logic [2:0]   m_lines_this;
  logic [15:0]  m_total;
  logic         m_top;
  logic         m_ov;
  logic [199:0] p_grid;
  int           p_k;
  logic         p_ov;

  always @(posedge clk or posedge reset) begin
    int n;
    int t;
    if (reset) begin
      m_cnt = 0; m_grid = '0; m_lines_this = '0; m_total = '0; m_top = 1'b0; m_ov = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        m_lines_this = 3'(p_k);
        t = int'(m_total) + p_k;
        m_total = (t > 65535) ? 16'hFFFF : t[15:0];
        m_top = |p_grid[9:0];
        m_grid = p_grid;
        m_ov = m_ov | p_ov;
      end
    end else if (clear_grid) begin
      m_grid = '0; m_lines_this = '0; m_total = '0; m_top = 1'b0; m_ov = 1'b0;
    end else if (lock_valid) begin
      p_ov = |(m_grid & lock_mask);
      clear_full_rows(m_grid | lock_mask, p_grid, n);
      p_k = (n > 7) ? 7 : n;
      // merge + one scan cycle per row + one rescan per cleared row + done
      m_cnt = 22 + n;
    end
  end

  // Per-cycle scoreboard against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("lock_ready", lock_ready, m_cnt == 0);
      check("busy", busy, m_cnt != 0);
      check("clear_done", clear_done, m_cnt == 1);
      check("lines_this_lock", lines_this_lock, m_lines_this);
      check("lines_total", lines_total, m_total);
      check("top_out", top_out, m_top);
      if (m_cnt <= 1) begin
        check("grid_state", grid_state, m_grid);
        check("overlap_err", overlap_err, m_ov);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [199:0] rand200();
    logic [223:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[199:0];
  endfunction

  function automatic logic [199:0] rows_mask(input int lo, input int hi, input logic [9:0] cols);
    logic [199:0] m = '0;
    for (int r = lo; r <= hi; r++) m[r*10 +: 10] = cols;
    return m;
  endfunction

  function automatic logic [199:0] rand_mask(input logic [199:0] g);
    logic [199:0] m = '0;
    int sel = $urandom_range(0, 3);
    int r0;
    int nr;
    if (sel <= 1) begin
      for (int i = 0; i < 4; i++) m[$urandom_range(120, 199)] = 1'b1;
    end else if (sel == 2) begin
      r0 = $urandom_range(16, 19);
      nr = ($urandom_range(0, 7) == 0) ? 8 : $urandom_range(1, 4);
      if (nr == 8) r0 = 19;
      for (int r = r0; r > r0 - nr; r--) m[r*10 +: 10] = ~g[r*10 +: 10];
    end else begin
      m = rand200() & rand200() & rand200();
    end
    return m;
  endfunction

  // Drive one lock from IDLE and count rising edges from acceptance to clear_done.
  task automatic do_lock(input logic [199:0] m, output int edges);
    bit got = 0;
    @(negedge clk);
    lock_valid = 1'b1;
    lock_mask  = m;
    @(posedge clk);
    @(negedge clk);
    lock_valid = 1'b0;
    lock_mask  = rand200();
    edges = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (clear_done) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lock_timeout: got no clear_done after %0d edges expected one", edges);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_grid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_grid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e;
    reset = 1'b1;
    lock_valid = 1'b0;
    lock_mask = '0;
    clear_grid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_grid", grid_state, '0);
    check("reset_ready", lock_ready, 1'b1);

    // Partial bottom row: nothing clears.
    do_lock(200'hF << 190, e);
    check("partial_edges", e, 21);
    check("partial_lines", lines_this_lock, 3'd0);
    check("partial_grid", grid_state, 200'hF << 190);
    check("partial_top", top_out, 1'b0);

    // Tetris: four rows missing column 9, then a vertical I.
    do_clear();
    do_lock(rows_mask(16, 19, 10'h1FF), e);
    check("prep4_edges", e, 21);
    do_lock(rows_mask(16, 19, 10'h200), e);
    check("tetris_edges", e, 25);
    check("tetris_lines", lines_this_lock, 3'd4);
    check("tetris_total", lines_total, 16'd4);
    check("tetris_grid", grid_state, '0);

    // Single clear drops the row above.
    do_clear();
    do_lock((200'h1 << 180) | rows_mask(19, 19, 10'h1FF), e);
    do_lock(200'h1 << 199, e);
    check("drop_edges", e, 22);
    check("drop_grid", grid_state, 200'h1 << 190);
    check("drop_total", lines_total, 16'd1);
    check("drop_lines", lines_this_lock, 3'd1);

    // Overlap is sticky until clear_grid.
    do_lock(200'h3 << 190, e);
    check("ovl_set", overlap_err, 1'b1);
    do_lock(200'h1 << 100, e);
    check("ovl_sticky", overlap_err, 1'b1);
    do_clear();
    check("ovl_cleared", overlap_err, 1'b0);

    // Reset in the middle of a scan.
    do_lock(rows_mask(19, 19, 10'h1FF), e);
    @(negedge clk);
    lock_valid = 1'b1;
    lock_mask  = 200'h1 << 199;
    @(posedge clk);
    @(negedge clk);
    lock_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_grid", grid_state, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    check("rst_total", lines_total, 16'd0);
    check("rst_lines", lines_this_lock, 3'd0);
    check("rst_ready", lock_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (30) @(negedge clk);
    do_lock(200'h1 << 195, e);
    check("post_rst_edges", e, 21);

    // Saturating total, then clear_grid beating a simultaneous lock.
    do_clear();
    @(negedge clk);
    #1;
    dut.r_lines_total = 16'd65534;
    m_total = 16'd65534;
    do_lock(rows_mask(18, 19, 10'h1FF), e);
    do_lock((200'h1 << 189) | (200'h1 << 199), e);
    check("sat_total", lines_total, 16'hFFFF);
    check("sat_lines", lines_this_lock, 3'd2);
    do_lock(200'h1 << 150, e);
    @(negedge clk);
    clear_grid = 1'b1;
    lock_valid = 1'b1;
    lock_mask  = 200'h1 << 195;
    @(posedge clk);
    @(negedge clk);
    clear_grid = 1'b0;
    lock_valid = 1'b0;
    check("cg_busy", busy, 1'b0);
    check("cg_grid", grid_state, '0);
    check("cg_total", lines_total, 16'd0);

    // Random traffic, inputs toggled freely even while busy.
    repeat (4000) begin
      @(negedge clk);
      lock_valid = ($urandom_range(0, 2) == 0);
      clear_grid = ($urandom_range(0, 29) == 0);
      lock_mask  = rand_mask(m_grid);
    end
    @(negedge clk);
    lock_valid = 1'b0;
    clear_grid = 1'b0;
    for (int i = 0; i < 100 && m_cnt != 0; i++) @(negedge clk);
    if (m_cnt != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got busy model count %0d expected 0", m_cnt);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_line_clear.md
TETRIS_LINE_CLEAR -- requirements
Module: tetris_line_clear

Interface
REQ-001 Grid geometry SHALL be 20 rows x 10 columns; cell (row r, col c) at bit r*10+c; row 0 top, row 19 bottom.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lock_valid  input  1  request to merge a landed piece.
REQ-005 lock_mask  input  200  cells occupied by the landed piece, same layout as grid_state.
REQ-006 lock_ready  output  1  block can accept a lock; high only in IDLE.
REQ-007 clear_grid  input  1  empty the playfield; honoured only in IDLE.
REQ-008 grid_state  output  200  registered playfield, drives the display system's grid input.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 clear_done  output  1  one-cycle pulse at end of each lock sequence.
REQ-011 lines_this_lock  output  3  rows cleared by the last lock (0-4), valid from clear_done onward.
REQ-012 lines_total  output  16  cumulative cleared rows, saturating.
REQ-013 top_out  output  1  row 0 non-empty after last lock sequence.
REQ-014 overlap_err  output  1  sticky: a lock_mask overlapped occupied cells.

Function
REQ-015 FSM states SHALL be IDLE, MERGE, SCAN, DONE; lock_ready = (state==IDLE) combinationally.
REQ-016 IDLE: lock_valid&&lock_ready -> latch lock_mask, go MERGE; else stay.
REQ-017 clear_grid and lock_valid both high in IDLE: clear_grid wins, lock not accepted, grid_state, lines_total, top_out, overlap_err, lines_this_lock -> 0.
REQ-018 clear_grid outside IDLE SHALL be ignored (not queued).
REQ-019 MERGE (1 cycle): grid <= grid | mask; if (grid & mask)!=0 set overlap_err; row pointer <= 19; per-lock count k <= 0; go SCAN.
REQ-020 SCAN, one row per cycle: if row ptr all 10 bits set -> rows 1..ptr take rows 0..ptr-1, row 0 <= 0, k <= k+1, ptr unchanged (rescan).
REQ-021 SCAN, row not full: ptr==0 -> DONE; else ptr <= ptr-1.
REQ-022 SCAN SHALL last exactly 20+k cycles; row 0 full clears it then rescans empty row 0.
REQ-023 k SHALL be 3 bits; k>4 cannot arise from legal tetrominoes but SHALL saturate at 7 without wrap.
REQ-024 DONE (1 cycle): clear_done=1, lines_this_lock <= k, lines_total <= min(lines_total+k, 65535), top_out <= |row 0; go IDLE.
REQ-025 clear_done SHALL rise 21+k edges after the accepting edge; lock_ready returns the cycle after clear_done.
REQ-026 grid_state SHALL change only in MERGE, SCAN-shift, clear_grid, or reset; stable otherwise.
REQ-027 lock_mask is sampled only on the accepting edge; later changes have no effect.
REQ-028 lines_this_lock, top_out SHALL hold until next DONE, clear_grid, or reset.

Reset
REQ-029 reset high SHALL immediately force: state IDLE, grid_state 0, busy 0, clear_done 0, lines_this_lock 0, lines_total 0, top_out 0, overlap_err 0, internal ptr/k/mask 0.
REQ-030 reset mid-sequence (MERGE/SCAN/DONE) SHALL abort without a clear_done pulse; lock_ready high the first cycle after reset deasserts.

Verification
REQ-031 Empty grid, lock mask bits 190..193 (partial row 19) -> clear_done at 21 edges, lines_this_lock 0, grid_state == mask, top_out 0.
REQ-032 Rows 16-19 full except col 9, lock vertical I at col 9 rows 16-19 -> clear_done at 25 edges, lines_this_lock 4, lines_total 4, grid_state all 0.
REQ-033 Row 19 full-1 cell, row 18 holds bit 180 only; lock completes row 19 -> row 19 now holds only bit 190, lines_total 1.
REQ-034 lock_mask overlapping an occupied cell -> overlap_err 1 and stays 1 across next lock; clear_grid -> 0.
REQ-035 Assert reset during SCAN cycle 5 -> all outputs 0 asynchronously, no clear_done; new lock accepted after release.
REQ-036 Preload lines_total 65534, clear 2 rows -> lines_total 65535; clear_grid+lock_valid same IDLE cycle -> grid 0, lock ignored.
